// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared MIPS datapath encodings for the ALU, ALU control and main
//            control units.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // ALU operation codes; 4'b1111 is reserved and never produced
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_LUI  = 4'b1011;
    localparam logic [3:0] ALU_SLLV = 4'b1100;
    localparam logic [3:0] ALU_SRLV = 4'b1101;
    localparam logic [3:0] ALU_SRAV = 4'b1110;

    // Operation classes issued by main control
    localparam logic [3:0] OPER_ADD  = 4'b0000;
    localparam logic [3:0] OPER_SUB  = 4'b0001;
    localparam logic [3:0] OPER_RTYP = 4'b0010;
    localparam logic [3:0] OPER_AND  = 4'b0011;
    localparam logic [3:0] OPER_OR   = 4'b0100;
    localparam logic [3:0] OPER_XOR  = 4'b0101;
    localparam logic [3:0] OPER_SLT  = 4'b0110;
    localparam logic [3:0] OPER_SLTU = 4'b0111;
    localparam logic [3:0] OPER_LUI  = 4'b1000;

    // R-type funct field values
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/alu_control_dec.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_dec
// Purpose  : Combinational decode of operation class and funct field into the
//            next ALU operation code and illegal-funct flag.
// Revision : 1.0 - initial release
// ============================================================================
module alu_control_dec
    import mips_pkg::*;
(
    input  logic [5:0] i_funct,
    input  logic [3:0] i_oper,
    output logic [3:0] o_alu_op,
    output logic       o_illegal
);

    always_comb begin
        o_alu_op  = ALU_ADD;
        o_illegal = 1'b0;
        case (i_oper)
            OPER_ADD:  o_alu_op = ALU_ADD;
            OPER_SUB:  o_alu_op = ALU_SUB;
            OPER_AND:  o_alu_op = ALU_AND;
            OPER_OR:   o_alu_op = ALU_OR;
            OPER_XOR:  o_alu_op = ALU_XOR;
            OPER_SLT:  o_alu_op = ALU_SLT;
            OPER_SLTU: o_alu_op = ALU_SLTU;
            OPER_LUI:  o_alu_op = ALU_LUI;
            OPER_RTYP: begin
                case (i_funct)
                    FUNCT_ADD, FUNCT_ADDU: o_alu_op = ALU_ADD;
                    FUNCT_SUB, FUNCT_SUBU: o_alu_op = ALU_SUB;
                    FUNCT_AND:  o_alu_op = ALU_AND;
                    FUNCT_OR:   o_alu_op = ALU_OR;
                    FUNCT_XOR:  o_alu_op = ALU_XOR;
                    FUNCT_NOR:  o_alu_op = ALU_NOR;
                    FUNCT_SLT:  o_alu_op = ALU_SLT;
                    FUNCT_SLTU: o_alu_op = ALU_SLTU;
                    FUNCT_SLL:  o_alu_op = ALU_SLL;
                    FUNCT_SRL:  o_alu_op = ALU_SRL;
                    FUNCT_SRA:  o_alu_op = ALU_SRA;
                    FUNCT_SLLV: o_alu_op = ALU_SLLV;
                    FUNCT_SRLV: o_alu_op = ALU_SRLV;
                    FUNCT_SRAV: o_alu_op = ALU_SRAV;
                    // jr uses the adder path for its target and is legal
                    FUNCT_JR:   o_alu_op = ALU_ADD;
                    default: begin
                        o_alu_op  = ALU_ADD;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            default:   o_alu_op = ALU_ADD;
        endcase
    end

endmodule : alu_control_dec
`default_nettype wire

// File: rtl/alu_control.sv
`default_nettype none
// ============================================================================
// Module   : alu_control
// Purpose  : Registered ALU-control decoder between main control and the ALU;
//            outputs hold for the full cycle after the sampling edge.
// Revision : 1.0 - initial release
// ============================================================================
module alu_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] funct,
    input  logic [3:0] oper,
    output logic [3:0] alu_op,
    output logic       illegal
);

    logic [3:0] w_next_alu_op;
    logic       w_next_illegal;
    logic [3:0] r_alu_op;
    logic       r_illegal;

    alu_control_dec u_dec (
        .i_funct   (funct),
        .i_oper    (oper),
        .o_alu_op  (w_next_alu_op),
        .o_illegal (w_next_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_op  <= ALU_ADD;
            r_illegal <= 1'b0;
        end else begin
            r_alu_op  <= w_next_alu_op;
            r_illegal <= w_next_illegal;
        end
    end

    assign alu_op  = r_alu_op;
    assign illegal = r_illegal;

endmodule : alu_control
`default_nettype wire

// File: tb/tb_alu_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_control
// Purpose  : Directed self-checking bench for the registered ALU-control
//            decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_control;

    logic       clk;
    logic       reset;
    logic [5:0] funct;
    logic [3:0] oper;
    logic [3:0] alu_op;
    logic       illegal;

    int checks;
    int errors;

    alu_control dut (
        .clk     (clk),
        .reset   (reset),
        .funct   (funct),
        .oper    (oper),
        .alu_op  (alu_op),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge
    task automatic drive(input logic [3:0] o, input logic [5:0] f);
        @(negedge clk);
        oper  = o;
        funct = f;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        oper  = 4'b0010;
        funct = 6'b100101;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (alu_op !== 4'b0000 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_immediate: alu_op=%b illegal=%b expected 0000/0", alu_op, illegal);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (alu_op !== 4'b0000 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: alu_op=%b illegal=%b expected 0000/0", alu_op, illegal);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add_class();
        drive(4'b0000, 6'b100100);
        checks++;
        if (alu_op !== 4'b0000 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL add_funct_ignored: alu_op=%b illegal=%b expected 0000/0", alu_op, illegal);
        end
        drive(4'b0010, 6'b100100);
        checks++;
        if (alu_op !== 4'b0100 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL rtype_and: alu_op=%b illegal=%b expected 0100/0", alu_op, illegal);
        end
    endtask

    task automatic test_rtype_sweep();
        logic [5:0] f_tab [17];
        logic [3:0] e_tab [17];
        f_tab = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                  6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                  6'b000011, 6'b000100, 6'b000110, 6'b000111, 6'b001000};
        e_tab = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0100, 4'b0101,
                  4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b0010, 4'b0011,
                  4'b1010, 4'b1100, 4'b1101, 4'b1110, 4'b0000};
        for (int i = 0; i < 17; i++) begin
            drive(4'b0010, f_tab[i]);
            checks++;
            if (alu_op !== e_tab[i] || illegal !== 1'b0) begin
                errors++;
                $display("FAIL rtype_funct_%b: alu_op=%b illegal=%b expected %b/0",
                         f_tab[i], alu_op, illegal, e_tab[i]);
            end
        end
    endtask

    task automatic test_immediate_classes();
        logic [3:0] o_tab [10];
        logic [3:0] e_tab [10];
        o_tab = '{4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
                  4'b0111, 4'b1000, 4'b1001, 4'b1100, 4'b1111};
        e_tab = '{4'b0001, 4'b0100, 4'b0101, 4'b0110, 4'b1000,
                  4'b1001, 4'b1011, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 10; i++) begin
            // A funct that is illegal for R-type must not leak through here
            drive(o_tab[i], 6'b111111);
            checks++;
            if (alu_op !== e_tab[i] || illegal !== 1'b0) begin
                errors++;
                $display("FAIL oper_%b: alu_op=%b illegal=%b expected %b/0",
                         o_tab[i], alu_op, illegal, e_tab[i]);
            end
        end
    endtask

    task automatic test_illegal_funct();
        drive(4'b0010, 6'b111111);
        checks++;
        if (alu_op !== 4'b0000 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_111111: alu_op=%b illegal=%b expected 0000/1", alu_op, illegal);
        end
        drive(4'b0011, 6'b111111);
        checks++;
        if (alu_op !== 4'b0100 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_non_rtype: alu_op=%b illegal=%b expected 0100/0", alu_op, illegal);
        end
        drive(4'b0010, 6'b000001);
        checks++;
        if (alu_op !== 4'b0000 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_000001: alu_op=%b illegal=%b expected 0000/1", alu_op, illegal);
        end
        drive(4'b0010, 6'b101000);
        checks++;
        if (alu_op !== 4'b0000 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_101000: alu_op=%b illegal=%b expected 0000/1", alu_op, illegal);
        end
    endtask

    task automatic test_async_reset_midstream();
        drive(4'b0010, 6'b100111);
        checks++;
        if (alu_op !== 4'b0111 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL midstream_nor: alu_op=%b illegal=%b expected 0111/0", alu_op, illegal);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (alu_op !== 4'b0000 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL midstream_reset: alu_op=%b illegal=%b expected 0000/0", alu_op, illegal);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (alu_op !== 4'b0000) begin
            errors++;
            $display("FAIL midstream_after_release: alu_op=%b expected 0000", alu_op);
        end
        @(posedge clk);
        #1;
        checks++;
        if (alu_op !== 4'b0111 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL midstream_reload: alu_op=%b illegal=%b expected 0111/0", alu_op, illegal);
        end
        // Reset across an illegal decode must also clear the flag
        drive(4'b0010, 6'b111110);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL midstream_illegal_clear: illegal=%b expected 0", illegal);
        end
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (alu_op !== 4'b0000 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL midstream_illegal_reload: alu_op=%b illegal=%b expected 0000/1", alu_op, illegal);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        oper   = 4'b0000;
        funct  = 6'b000000;
        test_reset();
        test_add_class();
        test_rtype_sweep();
        test_immediate_classes();
        test_illegal_funct();
        test_async_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_control
`default_nettype wire
